stopwatch_display_scan: RTL and testbench
=========================================

# stopwatch_display_scan

Six-digit, time-multiplexed seven-segment driver placed directly downstream of the stopwatch counter. It takes the stopwatch's BCD digits (minutes, seconds, hundredths) and scans them onto a common-anode display one digit at a time. It also provides leading-zero blanking, whole-display blinking and colon-style decimal points. All outputs are registered and active-low, and connect straight to board pins.

## Interface
- REFRESH_DIV, 100_000: clk cycles each digit is lit (100 MHz gives 1 kHz digit rate, ~167 Hz frame rate); legal range ≥ 2
- BLINK_FRAMES, 83: full scan frames per blink half-period (~0.5 s at defaults); legal range ≥ 1
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- min_10, min_1, sec_10, sec_1, milli_10, milli_1  in  4 each  BCD digits from the stopwatch
- blank_lead  in  1  1 = blank min_10 when it is 0
- blink  in  1  1 = blink the whole display (paused indication)
- an  out  6  anode enables, active-low; an[0] = milli_1 … an[5] = min_10
- seg  out  7  segments, active-low, {g,f,e,d,c,b,a}
- dp  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse when a full 6-digit scan completes

## Operation
- Prescaler `pre` counts 0..REFRESH_DIV-1 and wraps. `tick` is asserted when pre == REFRESH_DIV-1.
- Digit index `idx` is 0..5 and advances on `tick`; 5 wraps to 0.
- idx → digit and anode mapping: 0 milli_1, 1 milli_10, 2 sec_1, 3 sec_10, 4 min_1, 5 min_10. Anode an[idx] is low; all other anodes are high.
- Decoder, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10–15 → 0111111 (dash, g only). These codes are an error indication and must never be lit as a garbled digit.
- dp is low only when idx = 2 (sec_1) or idx = 4 (min_1), giving the separators mm.ss.hh. Otherwise dp is 1.
- Leading blank: when blank_lead = 1, idx = 5 and min_10 == 0:
  - an = 111111, seg = 1111111, dp = 1.
  - The slot still takes its full REFRESH_DIV cycles.
- Blink:
  - Frame counter `fc` counts completed frames 0..BLINK_FRAMES-1. On wrap it toggles `phase`; phase = 1 means visible.
  - While blink = 0: fc is held at 0, phase is held at 1, and the display is never gated.
  - While blink = 1 and phase = 0: an = 111111, seg = 1111111, dp = 1.
  - Scanning, idx and frame_done continue unaffected.
- frame_done = 1 on the cycle after the tick that wraps idx from 5 to 0. It is a registered pulse, exactly one cycle wide.
- Simultaneous events:
  - Blink gating overrides leading blank and the decoder.
  - A digit input change takes effect on the next registered update, even mid-slot.
  - No input is latched per slot.

## Timing
- Reset values (reset low at a clk edge):
  - pre = 0, idx = 0, fc = 0, phase = 1
  - an = 111111, seg = 1111111, dp = 1, frame_done = 0
- Reset asserted mid-scan or mid-blink returns all state to the reset values on that same edge.
- Outputs are registered every cycle from the current idx and inputs, with 1-cycle latency.
  - First edge with reset high: an = 111110, showing milli_1.
- idx increments on the edge where pre == REFRESH_DIV-1. an/seg/dp reflect the new idx one edge later.
  - Each anode is low for exactly REFRESH_DIV consecutive cycles, with no gap or overlap.
- First frame_done occurs 6·REFRESH_DIV+1 cycles after reset release. It then repeats every 6·REFRESH_DIV cycles.
- Blink phase toggles every BLINK_FRAMES·6·REFRESH_DIV cycles while blink = 1.
  - Deasserting blink restores visibility on the next edge.
- Counter widths: pre is sized by $clog2(REFRESH_DIV); fc by $clog2(BLINK_FRAMES)+1. No overflow is possible.

## Test plan
Sim parameters: REFRESH_DIV = 4, BLINK_FRAMES = 2.
- Reset check:
  - Stimulus: hold reset low 3 cycles with arbitrary inputs.
  - Required: an = 111111, seg = 1111111, dp = 1, frame_done = 0.
  - After release: first edge gives an = 111110; an then steps through 111101, 111011 … 011111 at 4-cycle intervals; frame_done pulses at cycle 25, then every 24 cycles.
- Digit decode:
  - Stimulus: inputs 1,2,3,4,5,6 (min_10..milli_1).
  - Required: seg is 0000010 for slot 0, then 0010010, 0011001, 0110000, 0100100, 1111001.
  - Required: dp is low only in slots 2 and 4.
- Error code:
  - Stimulus: sec_10 = 4'hC.
  - Required: seg = 0111111 during slot 3; all other slots decode normally.
- Leading blank:
  - Stimulus: min_10 = 0, blank_lead = 1.
  - Required: an = 111111 and seg = 1111111 for the 4 cycles of slot 5.
  - Stimulus: blank_lead = 0.
  - Required: an = 011111, seg = 1000000.
- Blink:
  - Stimulus: blink = 1.
  - Required: display visible for 2 frames (48 cycles), dark (an = 111111) for 48 cycles, then repeats; frame_done keeps pulsing throughout.
  - Stimulus: drop blink while dark.
  - Required: visible on the next edge.
- Mid-operation reset:
  - Stimulus: pull reset low during slot 3 with blink dark.
  - Required: all outputs return to reset values on that edge; after release, scanning restarts at slot 0 and the display is visible.

Source files
------------

// File: rtl/stopwatch_display_scan.sv
// Six-digit multiplexed seven-segment driver for the stopwatch (mm.ss.hh), with lead-zero blanking and blink.
// All outputs registered and active-low; one cycle of latency from idx and the digit inputs.
module stopwatch_display_scan #(
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLINK_FRAMES = 83
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] min_10,
  input  logic [3:0] min_1,
  input  logic [3:0] sec_10,
  input  logic [3:0] sec_1,
  input  logic [3:0] milli_10,
  input  logic [3:0] milli_1,
  input  logic       blank_lead,
  input  logic       blink,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FC_MAX  = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    idx_q, idx_d;
  logic [FW-1:0] fc_q, fc_d;
  logic          phase_q, phase_d;
  logic          wrap_q, wrap_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;
  logic          tick;
  logic          dark;
  logic [3:0]    digit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    tick    = (pre_q == PRE_MAX);
    pre_d   = tick ? '0 : pre_q + 1'b1;
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    // wrap_q delays the frame pulse so it lines up with slot 0 reappearing on the pins
    wrap_d       = tick && (idx_q == 3'd5);
    frame_done_d = wrap_q;

    fc_d    = fc_q;
    phase_d = phase_q;
    if (!blink) begin
      fc_d    = '0;
      phase_d = 1'b1;
    end else if (wrap_d) begin
      if (fc_q == FC_MAX) begin
        fc_d    = '0;
        phase_d = ~phase_q;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end

    case (idx_q)
      3'd0:    digit = milli_1;
      3'd1:    digit = milli_10;
      3'd2:    digit = sec_1;
      3'd3:    digit = sec_10;
      3'd4:    digit = min_1;
      default: digit = min_10;
    endcase

    dark = (blink && !phase_q) ||
           (blank_lead && (idx_q == 3'd5) && (min_10 == 4'd0));
    an_d  = ~(6'b000001 << idx_q);
    seg_d = decode(digit);
    dp_d  = !((idx_q == 3'd2) || (idx_q == 3'd4));
    if (dark) begin
      an_d  = 6'b111111;
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q        <= '0;
      idx_q        <= 3'd0;
      fc_q         <= '0;
      phase_q      <= 1'b1;
      wrap_q       <= 1'b0;
      an_q         <= 6'b111111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      fc_q         <= fc_d;
      phase_q      <= phase_d;
      wrap_q       <= wrap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Bench for stopwatch_display_scan: time-based reference model compared every cycle,
// plus directed literal expectations at known cycles after reset release.
module tb_stopwatch_display_scan;
  localparam int RD = 4;
  localparam int BF = 2;
  localparam int FRAME = 6 * RD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] min_10 = '0, min_1 = '0, sec_10 = '0, sec_1 = '0, milli_10 = '0, milli_1 = '0;
  logic       blank_lead = 1'b0;
  logic       blink = 1'b0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int c = 0;
  logic cmp_en = 1'b0;

  stopwatch_display_scan #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset),
    .min_10(min_10), .min_1(min_1), .sec_10(sec_10), .sec_1(sec_1),
    .milli_10(milli_10), .milli_1(milli_1),
    .blank_lead(blank_lead), .blink(blink),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tab [16];
    tab[0] = 7'b1000000; tab[1] = 7'b1111001; tab[2] = 7'b0100100; tab[3] = 7'b0110000;
    tab[4] = 7'b0011001; tab[5] = 7'b0010010; tab[6] = 7'b0000010; tab[7] = 7'b1111000;
    tab[8] = 7'b0000000; tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) tab[i] = 7'b0111111;
    return tab[d];
  endfunction

  // Reference model: everything derives from mt, the number of edges since reset release.
  int         mt = 0;
  int         mblk = 0;
  logic [5:0] exp_an = 6'h3f;
  logic [6:0] exp_seg = 7'h7f;
  logic       exp_dp = 1'b1;
  logic       exp_fd = 1'b0;

  always @(posedge clk) begin
    int slot;
    logic [3:0] dig;
    logic [5:0] a;
    bit vis, lead;
    if (!reset) begin
      mt <= 0; mblk <= 0;
      exp_an <= 6'h3f; exp_seg <= 7'h7f; exp_dp <= 1'b1; exp_fd <= 1'b0;
    end else begin
      slot = (mt / RD) % 6;
      case (slot)
        0: dig = milli_1;
        1: dig = milli_10;
        2: dig = sec_1;
        3: dig = sec_10;
        4: dig = min_1;
        default: dig = min_10;
      endcase
      vis  = !blink || (((mblk / BF) % 2) == 0);
      lead = blank_lead && (slot == 5) && (min_10 == 4'd0);
      if (!vis || lead) begin
        exp_an <= 6'h3f; exp_seg <= 7'h7f; exp_dp <= 1'b1;
      end else begin
        a = 6'h3f;
        a[slot] = 1'b0;
        exp_an  <= a;
        exp_seg <= seg_of(dig);
        exp_dp  <= !(slot == 2 || slot == 4);
      end
      exp_fd <= (mt > 0) && ((mt % FRAME) == 0);
      if (!blink) mblk <= 0;
      else if (((mt + 1) % FRAME) == 0) mblk <= mblk + 1;
      mt <= mt + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en)
      chk("cycle {an,seg,dp,fd}", 32'({an, seg, dp, frame_done}),
          32'({exp_an, exp_seg, exp_dp, exp_fd}));
  end

  task automatic step();
    @(posedge clk);
    #1;
    c++;
  endtask

  function automatic int slot_of(input int cyc);
    return ((cyc - 1) / RD) % 6;
  endfunction

  initial begin
    int dark_n, fd_n;
    min_10 = 4'($urandom); min_1 = 4'($urandom); sec_10 = 4'($urandom);
    sec_1 = 4'($urandom); milli_10 = 4'($urandom); milli_1 = 4'($urandom);
    blank_lead = 1'($urandom); blink = 1'($urandom);
    repeat (3) step();
    cmp_en = 1'b1;
    chk("reset an", 32'(an), 32'h3f);
    chk("reset seg", 32'(seg), 32'h7f);
    chk("reset dp", 32'(dp), 32'h1);
    chk("reset frame_done", 32'(frame_done), 32'h0);

    // Digit decode and scan order
    min_10 = 4'd1; min_1 = 4'd2; sec_10 = 4'd3; sec_1 = 4'd4; milli_10 = 4'd5; milli_1 = 4'd6;
    blank_lead = 1'b0; blink = 1'b0;
    reset = 1'b1;
    c = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (c == 1)  begin chk("slot0 an", 32'(an), 32'h3e); chk("slot0 seg", 32'(seg), 32'b0000010); end
      if (c == 4)  chk("slot0 held an", 32'(an), 32'h3e);
      if (c == 5)  begin chk("slot1 an", 32'(an), 32'h3d); chk("slot1 seg", 32'(seg), 32'b0010010); end
      if (c == 9)  begin chk("slot2 seg", 32'(seg), 32'b0011001); chk("slot2 dp", 32'(dp), 32'h0); end
      if (c == 13) begin chk("slot3 seg", 32'(seg), 32'b0110000); chk("slot3 dp", 32'(dp), 32'h1); end
      if (c == 17) begin chk("slot4 an", 32'(an), 32'h2f); chk("slot4 dp", 32'(dp), 32'h0); end
      if (c == 21) begin chk("slot5 an", 32'(an), 32'h1f); chk("slot5 seg", 32'(seg), 32'b1111001); end
      if (c == 24) chk("fd before", 32'(frame_done), 32'h0);
      if (c == 25) chk("fd first", 32'(frame_done), 32'h1);
      if (c == 26) chk("fd width", 32'(frame_done), 32'h0);
      if (c == 49) chk("fd second", 32'(frame_done), 32'h1);
    end

    // Error code on sec_10
    sec_10 = 4'hC;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (slot_of(c) == 3) chk("error dash seg", 32'(seg), 32'b0111111);
      if (slot_of(c) == 2) chk("error neighbour seg", 32'(seg), 32'b0011001);
    end

    // Leading-zero blanking
    min_10 = 4'd0; blank_lead = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (slot_of(c) == 5) begin
        chk("lead blank an", 32'(an), 32'h3f);
        chk("lead blank seg", 32'(seg), 32'h7f);
      end
    end
    blank_lead = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (slot_of(c) == 5) begin
        chk("lead shown an", 32'(an), 32'h1f);
        chk("lead shown seg", 32'(seg), 32'b1000000);
      end
    end

    // Blink from a frame boundary: 48 visible, 48 dark
    while ((c % FRAME) != 0) step();
    blink = 1'b1;
    dark_n = 0; fd_n = 0;
    for (int k = 1; k <= 150; k++) begin
      step();
      if (k <= 96 && an == 6'h3f) dark_n++;
      if (k <= 96 && frame_done) fd_n++;
      if (k == 48) chk("blink last visible an", 32'(an), 32'h1f);
      if (k == 49) chk("blink first dark an", 32'(an), 32'h3f);
      if (k == 97) chk("blink visible again an", 32'(an), 32'h3e);
      if (k == 150) chk("blink dark again an", 32'(an), 32'h3f);
    end
    chk("blink dark cycles", 32'(dark_n), 32'd48);
    chk("blink frame_done count", 32'(fd_n), 32'd4);
    blink = 1'b0;
    step();
    chk("unblink next edge an", 32'(an), 32'h3d);

    // Reset in slot 3 while dark
    while ((c % FRAME) != 0) step();
    blink = 1'b1;
    for (int k = 1; k <= 61; k++) step();
    chk("pre-reset dark an", 32'(an), 32'h3f);
    reset = 1'b0;
    step();
    chk("midreset an", 32'(an), 32'h3f);
    chk("midreset seg", 32'(seg), 32'h7f);
    chk("midreset dp", 32'(dp), 32'h1);
    chk("midreset fd", 32'(frame_done), 32'h0);
    step();
    reset = 1'b1;
    c = 0;
    step();
    chk("restart an", 32'(an), 32'h3e);
    chk("restart seg", 32'(seg), 32'b0000010);
    for (int k = 0; k < 30; k++) step();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
